// File: rtl/lcd_nibble_receiver.sv
// Receives HD44780-style LCD writes from an external master. It rebuilds the bytes
// from the 4-bit bus and emulates the controller busy window and the protocol error flags.
module lcd_nibble_receiver #(
    parameter int BUSY_CYCLES = 2000,
    parameter int MIN_EN_HIGH = 12
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLCD_Enabled,
    input  logic       iLCD_RegisterSelect,
    input  logic       iLCD_ReadWrite,
    input  logic [3:0] iLCD_Data,
    output logic [7:0] oData,
    output logic       oRS,
    output logic       oValid,
    output logic       oBusy,
    output logic       oNibbleMode,
    output logic       oPulseErr,
    output logic       oOverrun,
    output logic       oFrameErr
);
    localparam int CW = $clog2(MIN_EN_HIGH + 1);
    localparam int BW = $clog2(BUSY_CYCLES + 1);

    typedef enum logic [1:0] {BYTE8, HIGH, LOW} stateT;

    stateT         state;
    logic [6:0]    syncA;
    logic [6:0]    syncB;
    logic [6:0]    prevSync;
    logic [CW-1:0] highCount;
    logic [BW-1:0] busyCount;
    logic [3:0]    highNibble;
    logic          highRs;

    // The bus layout is {E, RS, RW, D[3:0]}. prevSync holds the last E-high sample
    // when a falling edge is seen.
    logic       fall;
    logic       strobeRs;
    logic       strobeRw;
    logic [3:0] strobeD;
    logic       legal;

    assign fall     = prevSync[6] & ~syncB[6];
    assign strobeRs = prevSync[5];
    assign strobeRw = prevSync[4];
    assign strobeD  = prevSync[3:0];
    assign legal    = (highCount >= CW'(MIN_EN_HIGH));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= BYTE8;
            syncA       <= '0;
            syncB       <= '0;
            prevSync    <= '0;
            highCount   <= '0;
            busyCount   <= '0;
            highNibble  <= '0;
            highRs      <= 1'b0;
            oData       <= '0;
            oRS         <= 1'b0;
            oValid      <= 1'b0;
            oBusy       <= 1'b0;
            oNibbleMode <= 1'b0;
            oPulseErr   <= 1'b0;
            oOverrun    <= 1'b0;
            oFrameErr   <= 1'b0;
        end else begin
            syncA    <= {iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_Data};
            syncB    <= syncA;
            prevSync <= syncB;

            if (!syncB[6])
                highCount <= '0;
            else if (highCount != CW'(MIN_EN_HIGH))
                highCount <= highCount + CW'(1);

            oValid    <= 1'b0;
            oPulseErr <= 1'b0;
            oOverrun  <= 1'b0;
            oFrameErr <= 1'b0;

            if (busyCount != '0)
                busyCount <= busyCount - BW'(1);
            else
                oBusy <= 1'b0;

            // Read strobes are ignored. Write strobes are checked in priority order:
            // first the width, then busy, then the decode.
            if (fall && !strobeRw) begin
                if (!legal) begin
                    oPulseErr <= 1'b1;
                end else if (oBusy) begin
                    oOverrun <= 1'b1;
                end else begin
                    case (state)
                        BYTE8: begin
                            oData     <= {strobeD, 4'h0};
                            oRS       <= strobeRs;
                            oValid    <= 1'b1;
                            oBusy     <= 1'b1;
                            busyCount <= BW'(BUSY_CYCLES - 1);
                            if (!strobeRs && strobeD == 4'h2) begin
                                state       <= HIGH;
                                oNibbleMode <= 1'b1;
                            end
                        end
                        HIGH: begin
                            highNibble <= strobeD;
                            highRs     <= strobeRs;
                            state      <= LOW;
                        end
                        LOW: begin
                            oData     <= {highNibble, strobeD};
                            oRS       <= highRs;
                            oValid    <= 1'b1;
                            oBusy     <= 1'b1;
                            busyCount <= BW'(BUSY_CYCLES - 1);
                            oFrameErr <= (strobeRs != highRs);
                            state     <= HIGH;
                        end
                        default: state <= BYTE8;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Testbench for lcd_nibble_receiver. It runs directed protocol scenarios and then
// random strobes, and compares them against a transaction-level model of the LCD protocol.
module tb_lcd_nibble_receiver;
    localparam int BUSY = 2000;
    localparam int MINW = 12;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iLCD_Enabled = 1'b0;
    logic       iLCD_RegisterSelect = 1'b0;
    logic       iLCD_ReadWrite = 1'b0;
    logic [3:0] iLCD_Data = 4'h0;
    logic [7:0] oData;
    logic       oRS, oValid, oBusy, oNibbleMode, oPulseErr, oOverrun, oFrameErr;

    lcd_nibble_receiver #(.BUSY_CYCLES(BUSY), .MIN_EN_HIGH(MINW)) dut (
        .Clock(Clock), .Reset(Reset),
        .iLCD_Enabled(iLCD_Enabled), .iLCD_RegisterSelect(iLCD_RegisterSelect),
        .iLCD_ReadWrite(iLCD_ReadWrite), .iLCD_Data(iLCD_Data),
        .oData(oData), .oRS(oRS), .oValid(oValid), .oBusy(oBusy),
        .oNibbleMode(oNibbleMode), .oPulseErr(oPulseErr), .oOverrun(oOverrun),
        .oFrameErr(oFrameErr)
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int busyLen = 0;
    int lastBusyLen = 0;
    int txn = 0;

    always @(posedge Clock) cyc++;

    always @(negedge Clock) begin
        if (oBusy === 1'b1) busyLen++;
        else if (busyLen > 0) begin
            lastBusyLen = busyLen;
            busyLen = 0;
        end
    end

    // Protocol model state
    bit         mNibble;
    bit         mPending;
    logic [3:0] mHighNib;
    bit         mHighRs;
    int         mValidCyc;
    logic [7:0] mData;
    bit         mRs;

    task automatic modelReset();
        mNibble = 0; mPending = 0; mHighNib = 4'h0; mHighRs = 0;
        mValidCyc = -100000; mData = 8'h00; mRs = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkPulse(input string tag, input int n, input int off, input bit exp);
        if (exp) begin
            chk({tag, "_count"}, n, 1);
            chk({tag, "_cycle"}, off, 3);
        end else begin
            chk({tag, "_count"}, n, 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Drives one E strobe, predicts the result from the protocol rules, observes the pulses and checks them.
    task automatic strobe(input bit rs, input bit rw, input logic [3:0] d, input int width);
        int c, vN, vOff, pN, pOff, oN, oOff, fN, fOff;
        bit eV, eP, eO, eF, busyNow;
        logic [7:0] capData;
        bit capRs;
        vN = 0; vOff = 0; pN = 0; pOff = 0; oN = 0; oOff = 0; fN = 0; fOff = 0;
        eV = 0; eP = 0; eO = 0; eF = 0;
        capData = 8'h00; capRs = 0;
        @(negedge Clock);
        iLCD_RegisterSelect = rs; iLCD_ReadWrite = rw; iLCD_Data = d; iLCD_Enabled = 1'b1;
        repeat (width) @(negedge Clock);
        iLCD_Enabled = 1'b0;
        c = cyc;
        busyNow = ((c + 3 - mValidCyc) >= 1) && ((c + 3 - mValidCyc) <= BUSY);
        if (!rw) begin
            if (width < MINW) eP = 1;
            else if (busyNow) eO = 1;
            else if (!mNibble) begin
                eV = 1; mData = {d, 4'h0}; mRs = rs;
                if (!rs && d == 4'h2) mNibble = 1;
            end else if (!mPending) begin
                mPending = 1; mHighNib = d; mHighRs = rs;
            end else begin
                eV = 1; mData = {mHighNib, d}; mRs = mHighRs;
                eF = (rs != mHighRs); mPending = 0;
            end
            if (eV) mValidCyc = c + 3;
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge Clock);
            if (oValid) begin vN++; vOff = i; capData = oData; capRs = oRS; end
            if (oPulseErr) begin pN++; pOff = i; end
            if (oOverrun) begin oN++; oOff = i; end
            if (oFrameErr) begin fN++; fOff = i; end
        end
        txn++;
        $display("txn %0d: rs=%0b rw=%0b d=%h width=%0d -> valid=%0d data=%h perr=%0d ovr=%0d ferr=%0d",
                 txn, rs, rw, d, width, vN, oData, pN, oN, fN);
        chkPulse("valid", vN, vOff, eV);
        chkPulse("pulse_err", pN, pOff, eP);
        chkPulse("overrun", oN, oOff, eO);
        chkPulse("frame_err", fN, fOff, eF);
        if (eV) begin
            chk("data_at_valid", capData, mData);
            chk("rs_at_valid", capRs, mRs);
        end
        chk("data_hold", oData, mData);
        chk("rs_hold", oRS, mRs);
        chk("nibble_mode", oNibbleMode, mNibble);
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_data"}, oData, 0);
        chk({tag, "_rs"}, oRS, 0);
        chk({tag, "_valid"}, oValid, 0);
        chk({tag, "_busy"}, oBusy, 0);
        chk({tag, "_mode"}, oNibbleMode, 0);
        chk({tag, "_errs"}, {oPulseErr, oOverrun, oFrameErr}, 0);
    endtask

    initial begin
        modelReset();
        idle(4);
        chkAllZero("reset");
        Reset = 1'b1;
        idle(4);
        chkAllZero("after_release");

        // Initialisation sequence into 4-bit mode
        for (int i = 0; i < 3; i++) begin
            strobe(0, 0, 4'h3, 20);
            idle(BUSY + 100);
        end
        strobe(0, 0, 4'h2, 20);
        idle(BUSY + 100);

        // Data byte 0x41 as two nibbles, busy window length
        strobe(1, 0, 4'h4, 20);
        strobe(1, 0, 4'h1, 20);
        idle(BUSY + 100);
        chk("busy_length", lastBusyLen, BUSY);

        // Short pulse, then a legal byte
        strobe(0, 0, 4'h5, 5);
        strobe(0, 0, 4'h3, 20);
        strobe(0, 0, 4'h9, 20);

        // Overrun on both nibbles, then 0x28 after busy clears
        idle(90);
        strobe(0, 0, 4'h2, 20);
        strobe(0, 0, 4'h8, 20);
        idle(BUSY + 100);
        strobe(0, 0, 4'h2, 20);
        strobe(0, 0, 4'h8, 20);
        idle(BUSY + 100);

        // Frame error with read strobes interleaved
        strobe(0, 0, 4'h6, 20);
        strobe(0, 1, 4'hA, 20);
        strobe(1, 0, 4'h5, 20);
        strobe(1, 1, 4'h3, 20);
        idle(BUSY + 100);

        // Reset while waiting for the low nibble
        strobe(1, 0, 4'h7, 20);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chkAllZero("reset_in_low");
        idle(3);
        Reset = 1'b1;
        modelReset();
        strobe(0, 0, 4'h3, 20);

        // Reset in the middle of the busy window
        idle(50);
        Reset = 1'b0;
        #1;
        chk("reset_mid_busy", oBusy, 0);
        idle(3);
        Reset = 1'b1;
        modelReset();

        // Random strobes
        for (int n = 0; n < 30; n++) begin
            bit rs, rw;
            logic [3:0] d;
            int w;
            rs = 1'($urandom_range(0, 1));
            rw = ($urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 3) == 0) ? 4'h2 : 4'($urandom_range(0, 15));
            if (!mNibble && $urandom_range(0, 1) == 0) rs = 0;
            w = $urandom_range(3, 25);
            strobe(rs, rw, d, w);
            if ($urandom_range(0, 2) == 0) idle(BUSY + 50);
            else idle($urandom_range(0, 400));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lcd_nibble_receiver.md
LCD_NIBBLE_RECEIVER -- requirements
Module: lcd_nibble_receiver

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 2000: post-byte busy window in clocks (40 us at 50 MHz).
REQ-002 SHALL have parameter MIN_EN_HIGH, default 12: minimum enable-high width in clocks for a legal strobe.
REQ-003 SHALL have port Clock, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port iLCD_Enabled, input, 1: LCD E strobe, asynchronous to Clock.
REQ-006 SHALL have port iLCD_RegisterSelect, input, 1: 0 = command, 1 = data.
REQ-007 SHALL have port iLCD_ReadWrite, input, 1: 0 = write, 1 = read.
REQ-008 SHALL have port iLCD_Data, input, 4: LCD DB7..DB4.
REQ-009 SHALL have port oData, output, 8: last reassembled byte.
REQ-010 SHALL have port oRS, output, 1: register select of the byte on oData.
REQ-011 SHALL have port oValid, output, 1: one-cycle pulse, oData/oRS are new.
REQ-012 SHALL have port oBusy, output, 1: emulated controller busy.
REQ-013 SHALL have port oNibbleMode, output, 1: 1 once 4-bit mode is entered.
REQ-014 SHALL have port oPulseErr, output, 1: one-cycle pulse, E high shorter than MIN_EN_HIGH.
REQ-015 SHALL have port oOverrun, output, 1: one-cycle pulse, write strobe during busy.
REQ-016 SHALL have port oFrameErr, output, 1: one-cycle pulse, RS differs between the two nibbles.

Function
REQ-017 SHALL pass all four inputs (E, RS, RW, D) through a 2-flop synchronizer and detect E falling edge on the synchronized E against its previous registered value.
REQ-018 SHALL sample RS, RW, and D from the synchronized copy aligned with the last E-high sample.
REQ-019 SHALL count consecutive synchronized E-high cycles, saturating at MIN_EN_HIGH.
REQ-020 SHALL ignore any falling edge with RW=1: no state change and no flags.
REQ-021 SHALL treat a write falling edge with count < MIN_EN_HIGH as illegal: pulse oPulseErr, drop the strobe, no state change.
REQ-022 SHALL treat a legal write strobe with oBusy=1 as overrun: pulse oOverrun, drop it, keep nibble state.
REQ-023 SHALL, for a legal, non-busy write strobe, act per state machine BYTE8 / HIGH / LOW as follows.
REQ-024 In BYTE8: emit oData={D,4'h0}, oRS=RS; if RS=0 and D=4'h2, go to HIGH and set oNibbleMode; else stay in BYTE8.
REQ-025 In HIGH: store D as the high nibble and RS; go to LOW; no emission, no busy.
REQ-026 In LOW: emit oData={high,D}, oRS=stored RS; if the current RS differs from the stored RS, pulse oFrameErr in the same cycle as oValid; go to HIGH.
REQ-027 SHALL keep oNibbleMode set until reset; there is no path back to BYTE8.
REQ-028 SHALL register emission so that oValid asserts on the 3rd rising edge, counting the first edge that samples E low as edge 1.
REQ-029 SHALL hold oData/oRS stable until the next emission.
REQ-030 SHALL assert oBusy from the oValid cycle for exactly BUSY_CYCLES clocks.
REQ-031 SHALL, on an emission at the last busy cycle, reload the busy counter.
REQ-032 SHALL keep all error pulses mutually exclusive per strobe, with priority pulse-width, then overrun, then frame.

Reset
REQ-033 SHALL, while Reset=0, immediately force state BYTE8, oData=0, oRS=0, oValid=0, oBusy=0, oNibbleMode=0, all error pulses 0, all counters and synchronizers 0.
REQ-034 SHALL, on reset mid-byte (in LOW) or mid-busy, discard the partial nibble and busy window.
REQ-035 SHALL not treat the first synchronized E sample after reset release as a falling edge.

Verification
REQ-036 Init sequence, 3x {RS=0,D=3} then {RS=0,D=2}, E high 20 clk, gaps > BUSY_CYCLES -> oValid x4 with oData 0x30,0x30,0x30,0x20, then oNibbleMode=1.
REQ-037 In nibble mode, write RS=1 nibbles 4 then 1 -> single oValid, oData=0x41, oRS=1, oBusy high 2000 clk, no oValid after the high nibble.
REQ-038 E high 5 clk, write -> oPulseErr pulse, no oValid, state unchanged; a following legal strobe still decodes correctly.
REQ-039 Second full byte started 100 clk after oValid -> oOverrun on each nibble strobe, no oValid; after busy clears, byte 0x28 decodes.
REQ-040 High nibble RS=0, low nibble RS=1 -> oValid with oRS=0 and oFrameErr pulse; RW=1 strobes interleaved produce no response; Reset low while in LOW -> BYTE8, all outputs 0.
